// File: rtl/uart_shift_engine_pkg.sv
// uart_shift_pkg: shared types and sizing helper for the UART shift engine
package uart_shift_pkg;
  typedef enum logic {IDLE, ACTIVE} shift_state_t;
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/uart_shift_engine_if.sv
// uart_shift_engine_if: control/data bundle between bit-timing control (master) and shift engine (slave)
//   load_en/parallel_in arm a frame, shift_en/serial_in drive one bit tick;
//   q/serial_out/count/busy/done/parity report engine state.
interface uart_shift_engine_if #(parameter int WIDTH = 9);
  import uart_shift_pkg::*;
  localparam int CW = cw_of(WIDTH);
  logic load_en;
  logic [WIDTH-1:0] parallel_in;
  logic shift_en;
  logic serial_in;
  logic [WIDTH-1:0] q;
  logic serial_out;
  logic [CW-1:0] count;
  logic busy;
  logic done;
  logic parity;
  modport master (output load_en, parallel_in, shift_en, serial_in,
                  input q, serial_out, count, busy, done, parity);
  modport slave (input load_en, parallel_in, shift_en, serial_in,
                 output q, serial_out, count, busy, done, parity);
endinterface

// File: rtl/uart_shift_engine_bit_counter.sv
// uart_bit_counter: CW-bit up counter with clear, enable and terminal-count flag
//   clk/rst: clock, async active-high reset; clr_i: synchronous clear (wins over en_i);
//   en_i: count up; cnt_o: current value; tc_o: cnt_o == TERM (counter saturates there).
module uart_bit_counter #(
  parameter int CW = 4,
  parameter int TERM = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic [CW-1:0] cnt_o,
  output logic tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == CW'(TERM);
  assign cnt_o = cnt_q;
  always_comb cnt_d = clr_i ? '0 : (en_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_shift_engine.sv
// uart_shift_engine: shared TX serialiser / RX deserialiser with bit counter and done handshake
//   clk/rst: clock, async active-high reset; bus: slave side of uart_shift_engine_if
//   (load_en has priority over shift_en; done pulses one cycle after the WIDTH-th shift).
module uart_shift_engine
  import uart_shift_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  uart_shift_engine_if.slave bus
);
  localparam int CW = cw_of(WIDTH);
  shift_state_t state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic done_q, done_d;
  logic [CW-1:0] cnt;
  logic tc, shift, last;
  assign shift = state_q == ACTIVE && bus.shift_en && !tc;
  assign last = cnt == CW'(WIDTH - 1);
  uart_bit_counter #(.CW(CW), .TERM(WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr_i(bus.load_en),
    .en_i(shift),
    .cnt_o(cnt),
    .tc_o(tc)
  );
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    done_d = 1'b0;
    if (bus.load_en) begin
      state_d = ACTIVE;
      q_d = bus.parallel_in;
    end else if (shift) begin
      q_d = LSB_FIRST ? {bus.serial_in, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], bus.serial_in};
      state_d = last ? IDLE : ACTIVE;
      done_d = last;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      q_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      done_q <= done_d;
    end
  assign bus.q = q_q;
  assign bus.serial_out = LSB_FIRST ? q_q[0] : q_q[WIDTH-1];
  assign bus.count = cnt;
  assign bus.busy = state_q == ACTIVE;
  assign bus.done = done_q;
  assign bus.parity = ^q_q;
endmodule

// File: tb/tb_uart_shift_engine.sv
// tb_uart_shift_engine: directed bench for two engine configurations against a word-level model
module tb_uart_shift_engine;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int m_q[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  bit m_busy[2] = '{0, 0};
  bit m_done[2] = '{0, 0};
  bit so_seen[9];
  uart_shift_engine_if #(.WIDTH(9)) ia ();
  uart_shift_engine_if #(.WIDTH(8)) ib ();
  uart_shift_engine #(.WIDTH(9), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  uart_shift_engine #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void step(input int i, input int w, input bit lsb, input bit ld,
                               input int pin, input bit sh, input bit si);
    m_done[i] = 1'b0;
    if (ld) begin
      m_q[i] = pin;
      m_cnt[i] = 0;
      m_busy[i] = 1'b1;
    end else if (m_busy[i] && sh) begin
      m_q[i] = lsb ? (m_q[i] >> 1) | (int'(si) << (w - 1))
                   : ((m_q[i] << 1) | int'(si)) & ((1 << w) - 1);
      m_cnt[i]++;
      if (m_cnt[i] == w) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b1;
      end
    end
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_q = '{0, 0};
      m_cnt = '{0, 0};
      m_busy = '{0, 0};
      m_done = '{0, 0};
    end else begin
      step(0, 9, 1'b1, ia.load_en, int'(ia.parallel_in), ia.shift_en, ia.serial_in);
      step(1, 8, 1'b0, ib.load_en, int'(ib.parallel_in), ib.shift_en, ib.serial_in);
    end
  always @(negedge clk)
    if (!rst) begin
      chk("a.q", int'(ia.q), m_q[0]);
      chk("a.count", int'(ia.count), m_cnt[0]);
      chk("a.busy", int'(ia.busy), int'(m_busy[0]));
      chk("a.done", int'(ia.done), int'(m_done[0]));
      chk("a.serial_out", int'(ia.serial_out), m_q[0] & 1);
      chk("a.parity", int'(ia.parity), $countones(m_q[0]) & 1);
      chk("b.q", int'(ib.q), m_q[1]);
      chk("b.count", int'(ib.count), m_cnt[1]);
      chk("b.busy", int'(ib.busy), int'(m_busy[1]));
      chk("b.done", int'(ib.done), int'(m_done[1]));
      chk("b.serial_out", int'(ib.serial_out), (m_q[1] >> 7) & 1);
      chk("b.parity", int'(ib.parity), $countones(m_q[1]) & 1);
    end
  task automatic idle_inputs();
    ia.load_en = 0; ia.parallel_in = '0; ia.shift_en = 0; ia.serial_in = 0;
    ib.load_en = 0; ib.parallel_in = '0; ib.shift_en = 0; ib.serial_in = 0;
  endtask
  task automatic cyc(input bit la, input int pa, input bit sa, input bit sia,
                     input bit lb, input int pb, input bit sb, input bit sib);
    ia.load_en = la; ia.parallel_in = pa[8:0]; ia.shift_en = sa; ia.serial_in = sia;
    ib.load_en = lb; ib.parallel_in = pb[7:0]; ib.shift_en = sb; ib.serial_in = sib;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask
  initial begin
    bit [7:0] rx_bits;
    rx_bits = 8'b1011_0010;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst a.q", int'(ia.q), 0);
    chk("rst a.count", int'(ia.count), 0);
    chk("rst a.busy", int'(ia.busy), 0);
    chk("rst a.done", int'(ia.done), 0);
    chk("rst a.serial_out", int'(ia.serial_out), 0);
    chk("rst a.parity", int'(ia.parity), 0);
    chk("rst b.q", int'(ib.q), 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 1, 0, 0, 1, 1);
    chk("idle a.q", int'(ia.q), 0);
    chk("idle a.count", int'(ia.count), 0);
    chk("idle b.q", int'(ib.q), 0);
    cyc(1, 'h1A5, 0, 0, 1, 'h00, 0, 0);
    for (int k = 0; k < 9; k++) begin
      so_seen[k] = ia.serial_out;
      cyc(0, 0, 1, 1, 0, 0, k < 8, k < 8 ? rx_bits[7 - k] : 1'b0);
      if (k == 7) begin
        chk("rx b.q", int'(ib.q), 'hB2);
        chk("rx b.parity", int'(ib.parity), 0);
        chk("rx b.done", int'(ib.done), 1);
        chk("rx b.busy", int'(ib.busy), 0);
      end
    end
    for (int k = 0; k < 9; k++) chk($sformatf("tx bit%0d", k), int'(so_seen[k]), int'(k == 1 || k == 3 || k == 4 || k == 6 ? 1'b0 : 1'b1));
    chk("tx a.q", int'(ia.q), 'h1FF);
    chk("tx a.count", int'(ia.count), 9);
    chk("tx a.done", int'(ia.done), 1);
    chk("tx a.busy", int'(ia.busy), 0);
    chk("rx b.done cleared", int'(ib.done), 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 0, 0, 1, 0);
    chk("post-done a.q", int'(ia.q), 'h1FF);
    chk("post-done a.count", int'(ia.count), 9);
    chk("post-done a.done", int'(ia.done), 0);
    chk("post-done b.q", int'(ib.q), 'hB2);
    cyc(1, 'h0F0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 'h155, 1, 1, 0, 0, 0, 0);
    chk("reload a.q", int'(ia.q), 'h155);
    chk("reload a.count", int'(ia.count), 0);
    chk("reload a.busy", int'(ia.busy), 1);
    chk("reload a.done", int'(ia.done), 0);
    for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("reload end a.q", int'(ia.q), 0);
    chk("reload end a.done", int'(ia.done), 1);
    cyc(1, 'h1FF, 0, 0, 1, 'hFF, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("abort a.q", int'(ia.q), 0);
    chk("abort a.count", int'(ia.count), 0);
    chk("abort a.busy", int'(ia.busy), 0);
    chk("abort a.done", int'(ia.done), 0);
    chk("abort a.serial_out", int'(ia.serial_out), 0);
    chk("abort a.parity", int'(ia.parity), 0);
    chk("abort b.q", int'(ib.q), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 'h0AB, 0, 0, 1, 'h5A, 0, 0);
    chk("after abort a.q", int'(ia.q), 'h0AB);
    chk("after abort a.busy", int'(ia.busy), 1);
    for (int k = 0; k < 9; k++) cyc(0, 0, 1, 1, 0, 0, 1, 0);
    chk("after abort a.q end", int'(ia.q), 'h1FF);
    cyc(1, 'h012, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 'h0C3, 1, 1, 0, 0, 0, 0);
    chk("race a.q", int'(ia.q), 'h0C3);
    chk("race a.count", int'(ia.count), 0);
    chk("race a.done", int'(ia.done), 0);
    chk("race a.busy", int'(ia.busy), 1);
    for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_shift_engine.md
# uart_shift_engine

Parametrised shift engine for the UART datapath: one register serves as TX serialiser and RX deserialiser. Generalises the fixed 9-bit right-shift register with configurable width and bit order, a bit counter, busy/done handshake and a parity output. Sits between the UART baud/bit-timing control and the TX/RX framing logic. Control issues one `load_en` per frame and one `shift_en` per bit tick.

## Interface
Parameters:
- `WIDTH`, 9: frame payload bits (data + optional parity); legal range 2..16.
- `LSB_FIRST`, 1: 1 = shift right, LSB leaves first; 0 = shift left, MSB leaves first.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_en`  in  1  parallel load + arm; starts a frame.
- `parallel_in`  in  WIDTH  word loaded on `load_en`.
- `shift_en`  in  1  one-bit shift request (bit tick).
- `serial_in`  in  1  bit entering the vacated end on a shift.
- `q`  out  WIDTH  register contents.
- `serial_out`  out  1  outgoing bit: `q[0]` if LSB_FIRST, else `q[WIDTH-1]`.
- `count`  out  CW = $clog2(WIDTH+1)  bits shifted since last load.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the final shift.
- `parity`  out  1  XOR of all `q` bits (even-parity bit of current contents).

## Operation
- States: IDLE, ACTIVE.
- IDLE: `shift_en` ignored (q, count hold). `load_en` -> q = parallel_in, count = 0, go ACTIVE.
- ACTIVE, `shift_en`:
  - LSB_FIRST=1: q = {serial_in, q[WIDTH-1:1]}.
  - LSB_FIRST=0: q = {q[WIDTH-2:0], serial_in}.
  - count += 1.
- ACTIVE, shift that takes count to WIDTH: go IDLE; `done` = 1 for the following cycle; count holds WIDTH until the next load.
- `load_en` has priority over `shift_en` in every state. A load during ACTIVE restarts the frame: count = 0, stays ACTIVE, no `done`.
- After exactly WIDTH shifts, TX bits have all left via `serial_out`; RX bits have all arrived in `q`. Both directions run concurrently.
- `count` never exceeds WIDTH and never wraps.
- `serial_out` and `parity` are combinational from `q` only.

## Timing
- Reset (async assert, deassertion synchronous to clk): q = 0, count = 0, busy = 0, done = 0, serial_out = 0, parity = 0, state IDLE.
- Reset mid-frame aborts immediately; no `done`.
- `load_en` at edge N: q, count, busy valid after edge N. `serial_out` shows the first bit in the same cycle.
- Each `shift_en` at an edge updates q and count at that edge. Shifts need not be back-to-back.
- Final shift at edge N: busy = 0 after N; done = 1 from N to N+1; cleared at N+1 unless another completion occurs (impossible without a reload).
- `load_en` at the same edge as the final shift: load wins, no `done`, frame restarts.

## Structure
- Package `uart_shift_pkg`:
  - `shift_state_t` enum {IDLE, ACTIVE}.
  - localparam function for CW.
- Sub-module `uart_bit_counter`: parametrised CW-bit counter with clear, enable and terminal-count (== WIDTH) flag. Used by this block and reusable by the baud divider.
- Shift datapath and FSM stay in `uart_shift_engine`.

## Test plan
- WIDTH=9, LSB_FIRST=1: load 9'h1A5, 9 shifts with serial_in=1 -> serial_out 1,0,1,0,0,1,0,1,1; final q=9'h1FF, count=9, done one cycle, busy=0.
- WIDTH=8, LSB_FIRST=0: load 8'h00, shift in 1,0,1,1,0,0,1,0 -> q=8'hB2, parity=0, done pulse once.
- Shift_en in IDLE after reset and after done, 5 pulses -> q, count unchanged; no done.
- Load 9'h0F0, 4 shifts, then load 9'h155 with shift_en also high -> q=9'h155, count=0, busy=1, no done; 9 further shifts complete normally.
- Assert rst after 3 of 9 shifts -> all outputs 0 immediately (async); no done; next load works.
- Load and final shift on the same edge -> done stays 0, q=parallel_in, count=0.
